// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - parametrised serial sequence detector with loadable pattern and saturating match counter
module seq_det_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_ld,
    input  logic [LEN-1:0]   pat_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN-1:0]   pat_cur
);

    localparam int             FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FILL_LAST = FW'(LEN - 1);

    // FILL: fewer than LEN valid bits seen since the last restart; FULL: a
    // complete window is available and every valid bit can complete a match.
    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e           state, state_nx;
    logic [FW-1:0]    fill, fill_nx;
    logic [LEN-1:0]   hist, hist_nx;
    logic [LEN-1:0]   nh;
    logic [LEN-1:0]   pat_nx;
    logic             z_nx;
    logic             match;
    logic [CNT_W-1:0] cnt_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FILL;
            fill        <= '0;
            hist        <= '0;
            z           <= 1'b0;
            match_count <= '0;
            pat_cur     <= PATTERN;
        end else begin
            state       <= state_nx;
            fill        <= fill_nx;
            hist        <= hist_nx;
            z           <= z_nx;
            match_count <= cnt_nx;
            pat_cur     <= pat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fill_nx  = fill;
        hist_nx  = hist;
        pat_nx   = pat_cur;
        z_nx     = 1'b0;
        match    = 1'b0;
        nh       = {hist[LEN-2:0], x};

        if (pat_ld) begin
            pat_nx   = pat_in;
            hist_nx  = '0;
            fill_nx  = '0;
            state_nx = S_FILL;
        end else if (x_valid) begin
            hist_nx = nh;
            // The reset history can equal the pattern, so a match needs a full window.
            match   = ((state == S_FULL) || (fill == FILL_LAST)) && (nh == pat_cur);
            if (state == S_FILL) begin
                fill_nx = fill + 1'b1;
                if (fill == FILL_LAST) begin
                    state_nx = S_FULL;
                end
            end
            if (match && !OVERLAP) begin
                state_nx = S_FILL;
                fill_nx  = '0;
            end
            z_nx = match;
        end
    end

    always_comb begin
        cnt_nx = match_count;
        if (cnt_clr) begin
            cnt_nx = '0;
        end else if (match && !(&match_count)) begin
            cnt_nx = match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - randomized and directed bench for seq_det_param against a queue-based model
module tb_seq_det_param;

    localparam int LEN = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           x;
    logic           x_valid;
    logic           pat_ld;
    logic [LEN-1:0] pat_in;
    logic           cnt_clr;

    logic           z_ov, z_no, z_c2;
    logic [7:0]     cnt_ov, cnt_no;
    logic [1:0]     cnt_c2;
    logic [LEN-1:0] pat_ov, pat_no, pat_c2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_det_param #(.LEN(LEN), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_ld(pat_ld), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .z(z_ov), .match_count(cnt_ov), .pat_cur(pat_ov)
    );
    seq_det_param #(.LEN(LEN), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_ld(pat_ld), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .z(z_no), .match_count(cnt_no), .pat_cur(pat_no)
    );
    seq_det_param #(.LEN(LEN), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_ld(pat_ld), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .z(z_c2), .match_count(cnt_c2), .pat_cur(pat_c2)
    );

    // Model state per instance: 0 = overlap, 1 = non-overlap, 2 = overlap with 2-bit counter.
    bit             m_ov   [3] = '{1'b1, 1'b0, 1'b1};
    int             m_max  [3] = '{255, 255, 3};
    bit             m_q    [3][$];
    bit             m_z    [3];
    int             m_cnt  [3];
    logic [LEN-1:0] m_pat  [3];
    bit             n_z    [3];
    int             n_cnt  [3];
    logic [LEN-1:0] n_pat  [3];

    logic           d_z    [3];
    int             d_cnt  [3];
    logic [LEN-1:0] d_pat  [3];

    always_comb begin
        d_z[0] = z_ov;  d_z[1] = z_no;  d_z[2] = z_c2;
        d_cnt[0] = int'(cnt_ov); d_cnt[1] = int'(cnt_no); d_cnt[2] = int'(cnt_c2);
        d_pat[0] = pat_ov; d_pat[1] = pat_no; d_pat[2] = pat_c2;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit window_matches(input int k, input logic [LEN-1:0] p);
        if (m_q[k].size() != LEN) return 1'b0;
        for (int i = 0; i < LEN; i++) begin
            if (m_q[k][i] != p[LEN-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Compute next expected outputs from the current inputs; committed at the edge.
    task automatic model_next();
        bit hit;
        for (int k = 0; k < 3; k++) begin
            hit = 1'b0;
            n_z[k] = 1'b0;
            n_cnt[k] = m_cnt[k];
            n_pat[k] = m_pat[k];
            if (!reset) begin
                m_q[k].delete();
                n_cnt[k] = 0;
                n_pat[k] = 4'b1101;
            end else begin
                if (pat_ld) begin
                    n_pat[k] = pat_in;
                    m_q[k].delete();
                end else if (x_valid) begin
                    m_q[k].push_back(x);
                    if (m_q[k].size() > LEN) void'(m_q[k].pop_front());
                    hit = window_matches(k, m_pat[k]);
                    n_z[k] = hit;
                    if (hit && !m_ov[k]) m_q[k].delete();
                end
                if (cnt_clr) n_cnt[k] = 0;
                else if (hit && m_cnt[k] < m_max[k]) n_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic xv, input logic xb, input logic pl,
                        input logic [LEN-1:0] pi, input logic cc);
        reset = r; x_valid = xv; x = xb; pat_ld = pl; pat_in = pi; cnt_clr = cc;
        model_next();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_z[k] = n_z[k]; m_cnt[k] = n_cnt[k]; m_pat[k] = n_pat[k];
        end
        #1;
    endtask

    task automatic bitin(input logic b);
        step(1'b1, 1'b1, b, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic gap();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("z[%0d]", k), int'(d_z[k]), int'(m_z[k]));
                check($sformatf("match_count[%0d]", k), d_cnt[k], m_cnt[k]);
                check($sformatf("pat_cur[%0d]", k), int'(d_pat[k]), int'(m_pat[k]));
            end
        end
    end

    initial begin
        logic [6:0]  s7;
        logic [15:0] s16;
        reset = 1'b0; x = 1'b0; x_valid = 1'b0; pat_ld = 1'b0; pat_in = '0; cnt_clr = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check("reset_z", int'(z_ov), 0);
        check("reset_cnt", int'(cnt_ov), 0);
        check("reset_pat", int'(pat_ov), 13);

        // T1/T2: stream 1101101
        s7 = 7'b1101101;
        for (int i = 6; i >= 0; i--) begin
            bitin(s7[i]);
            if (i == 3) begin
                check("t1_z_bit4", int'(z_ov), 1);
                check("t2_z_bit4", int'(z_no), 1);
            end
            if (i == 2) check("t1_z_bit5", int'(z_ov), 0);
        end
        check("t1_z_bit7", int'(z_ov), 1);
        check("t2_z_bit7", int'(z_no), 0);
        check("t1_cnt", int'(cnt_ov), 2);
        check("t2_cnt", int'(cnt_no), 1);

        // T3: gaps between bits
        do_reset();
        bitin(1'b1); gap(); gap();
        bitin(1'b1); gap(); gap();
        bitin(1'b0); check("t3_z_gap", int'(z_ov), 0); gap(); gap();
        bitin(1'b1);
        check("t3_z_last", int'(z_ov), 1);
        gap();
        check("t3_z_after", int'(z_ov), 0);

        // T4: load all-zero pattern mid-stream
        do_reset();
        bitin(1'b1); bitin(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
        bitin(1'b0); bitin(1'b0); bitin(1'b0);
        check("t4_z_three", int'(z_ov), 0);
        bitin(1'b0);
        check("t4_z_four", int'(z_ov), 1);
        check("t4_pat", int'(pat_ov), 0);

        // T5: reset during a partial match
        bitin(1'b1); bitin(1'b1); bitin(1'b0);
        do_reset();
        check("t5_z", int'(z_ov), 0);
        check("t5_cnt", int'(cnt_ov), 0);
        check("t5_pat", int'(pat_ov), 13);
        bitin(1'b1);
        check("t5_z_after", int'(z_ov), 0);

        // T6: saturation at 3 on the 2-bit counter, then clear colliding with a match
        do_reset();
        s16 = 16'b1101101101101101;
        for (int i = 15; i >= 0; i--) bitin(s16[i]);
        check("t6_cnt_c2", int'(cnt_c2), 3);
        check("t6_cnt_ov", int'(cnt_ov), 5);
        bitin(1'b1); bitin(1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        check("t6_clr_cnt", int'(cnt_c2), 0);
        check("t6_clr_z", int'(z_c2), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            step(logic'($urandom_range(0, 199) != 0),
                 logic'($urandom_range(0, 9) < 7),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 49) == 0),
                 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
